uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive buffer directly downstream of the UART receive controller.
//   - Captures each byte strobed out by the receiver (rx_done pulse + rx_data).
//   - Holds bytes in a circular FIFO, first-word-fall-through, for the user logic.
//   - Reports full/empty/level and a sticky overflow flag. Runs in the UART clock domain.
// PARAMETERS
//   DATA_W    8    byte width, must match the receiver data output
//   DEPTH     16   FIFO entries; power of 2, >= 4
//   AF_LEVEL  12   almost-full threshold (entries); only used with the optional feature
// PORTS
//   clk        in   1                  system clock, rising edge
//   rst_n      in   1                  asynchronous active-low reset
//   rx_data    in   DATA_W             byte from the receive controller
//   rx_done    in   1                  1-cycle strobe: rx_data valid
//   rx_err     in   1                  framing error, qualified by rx_done
//   rd_en      in   1                  consumer pops head entry
//   rd_data    out  DATA_W             head entry (FWFT); valid when !empty
//   empty      out  1                  no entries
//   full       out  1                  DEPTH entries
//   level      out  $clog2(DEPTH)+1    current entry count, 0..DEPTH
//   overflow   out  1                  sticky: a byte was dropped because the FIFO was full
//   ovf_clr    in   1                  clears overflow (and frame_err)
//   almost_full out 1                  level >= AF_LEVEL (optional feature only, else tied 0)
//   frame_err  out  1                  sticky framing-error flag (optional feature only, else tied 0)
// BEHAVIOUR
//   Reset (async, rst_n=0): wr_ptr=rd_ptr=0; level=0; empty=1; full=0; overflow=0;
//     almost_full=0; frame_err=0. Storage contents not reset. rd_data is 0 while empty.
//   Pointers: $clog2(DEPTH) bits each. They wrap DEPTH-1 -> 0 with natural overflow.
//     Count is kept as a separate register; no extra-bit pointer compare.
//   Write: rx_done=1 && !full -> mem[wr_ptr]<=rx_data, wr_ptr++.
//   Write when full: rx_done=1 && full -> byte dropped, overflow<=1 next cycle.
//     Pointers and level are unchanged.
//   Read: rd_en=1 && !empty -> rd_ptr++. rd_data is mem[rd_ptr], combinational from the array.
//   Read when empty: rd_en && empty -> ignored, no state change.
//   Latency: byte written at edge N appears on rd_data, with empty=0, after edge N (1 cycle).
//   Simultaneous rd_en && rx_done:
//     - !empty && !full -> both occur, level unchanged.
//     - full -> read and write both occur; no drop, overflow unchanged.
//     - empty -> write only, level becomes 1.
//   Flags: empty/full/level are registered and updated on the same edge as the pointers.
//   Sticky flags: overflow clears only on ovf_clr=1. Set has priority if set and ovf_clr
//     occur in the same cycle.
//   rx_err without the feature is ignored; the byte is stored normally.
//   No handshake back to the receiver: rx_done is never stalled.
// CONFIGURATION
//   Macro UART_RX_FIFO_STATUS_EN:
//   - Defined:
//     - rx_done && rx_err -> byte discarded, frame_err<=1 (sticky, cleared by ovf_clr,
//       set wins over clear).
//     - almost_full is a registered output, level_next >= AF_LEVEL.
//   - Undefined: frame_err and almost_full tied 0; rx_err unused; no extra flops.
// STRUCTURE
//   - Shared header uart_defs.vh holds:
//     - CLK_PER default 100_000_000
//     - UART_DATA_W = 8
//     - the FIFO depth default
//     The receiver, transmitter and this block all include it.
//   - One sub-module: uart_fifo_mem (DEPTH x DATA_W register array).
//     Synchronous write, asynchronous read, no reset.
//   - Pointer, level and flag logic stay in this module.
// TESTING
//   1 Reset: rst_n low mid-traffic (level=5) -> next cycle empty=1, level=0, overflow=0, full=0.
//   2 Order: write 0x11,0x22,0x33, then pop 3 -> rd_data 0x11,0x22,0x33 in order, then empty=1.
//   3 Overflow: 17 writes 0x00..0x10 with DEPTH=16 -> full=1, overflow=1,
//       16 pops return 0x00..0x0F; ovf_clr -> overflow=0.
//   4 Wrap: 40 write/read pairs interleaved -> data intact across pointer wrap, level never >1.
//   5 Simultaneous: full FIFO, rd_en && rx_done(0xAA) -> level stays 16, overflow=0,
//       0xAA is the last byte popped.
//       Empty FIFO, rd_en && rx_done(0x55) -> level=1, rd_data=0x55.
//   6 Feature on: rx_done with rx_err=1, data 0x7E -> not stored, frame_err=1.
//       12 writes -> almost_full=1. Feature off: same 0x7E is stored.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants used by the receiver, transmitter and rx FIFO.
// Holds the system clock default, data width and FIFO sizing defaults.
package uart_rx_fifo_pkg;
  localparam int CLK_PER       = 100_000_000;
  localparam int UART_DATA_W   = 8;
  localparam int FIFO_DEPTH    = 16;
  localparam int FIFO_AF_LEVEL = 12;
endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W register array.
// Synchronous write, asynchronous read, contents never reset.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // store incoming byte at the write pointer
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FWFT circular FIFO with level and sticky flags.
// Macro UART_RX_FIFO_STATUS_EN adds frame_err and almost_full.
import uart_rx_fifo_pkg::*;

module uart_rx_fifo #(
  parameter int DATA_W   = UART_DATA_W,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AF_LEVEL = FIFO_AF_LEVEL,
  localparam int PW      = $clog2(DEPTH),
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              rx_err,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [LW-1:0]     level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              almost_full,
  output logic              frame_err
);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              empty_q, full_q, ovf_q;
  logic              empty_d, full_d, ovf_d;
  logic              rd_ok, wr_ok, drop, bad;
  logic [DATA_W-1:0] mem_rdata;

`ifdef UART_RX_FIFO_STATUS_EN
  logic ferr_q, ferr_d, af_q, af_d;
  assign bad = rx_done && rx_err;
`else
  logic unused_cfg;
  assign bad        = 1'b0;
  assign unused_cfg = rx_err ^ AF_LEVEL[0];
`endif

  // pointer, level and sticky-flag next state
  always_comb begin
    rd_ok    = rd_en && !empty_q;
    wr_ok    = rx_done && !bad && (!full_q || rd_ok);
    drop     = rx_done && !bad && full_q && !rd_ok;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_ok && !rd_ok) level_d = level_q + LW'(1);
    if (!wr_ok && rd_ok) level_d = level_q - LW'(1);
    empty_d = (level_d == '0);
    full_d  = (level_d == LW'(DEPTH));
    ovf_d   = drop | (ovf_q & ~ovf_clr);
`ifdef UART_RX_FIFO_STATUS_EN
    ferr_d  = bad | (ferr_q & ~ovf_clr);
    af_d    = (int'(level_d) >= AF_LEVEL);
`endif
  end

  // state registers, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef UART_RX_FIFO_STATUS_EN
  // status flags only present with the feature enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ferr_q <= 1'b0;
      af_q   <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      af_q   <= af_d;
    end
  end
  assign frame_err   = ferr_q;
  assign almost_full = af_q;
`else
  assign frame_err   = 1'b0;
  assign almost_full = 1'b0;
`endif

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign rd_data  = empty_q ? '0 : mem_rdata;
  assign empty    = empty_q;
  assign full     = full_q;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo (DEPTH=16).
// Honours UART_RX_FIFO_STATUS_EN for the status-flag checks.
module tb_uart_rx_fifo;

  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] rx_data = 0;
  logic       rx_done = 0;
  logic       rx_err = 0;
  logic       rd_en = 0;
  logic       ovf_clr = 0;
  logic [7:0] rd_data;
  logic       empty, full, overflow;
  logic       almost_full, frame_err;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;
  int mdl = 0;
  int maxlvl;
  logic [7:0] sb [$];

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_err      (rx_err),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .almost_full (almost_full),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(logic [7:0] d);
    rx_data = d;
    rx_done = 1;
    if (mdl < 16) begin
      sb.push_back(d);
      mdl++;
    end
    tick();
    rx_done = 0;
  endtask

  task automatic pop(string tag);
    logic [7:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk(tag, rd_data, e);
    rd_en = 1;
    mdl--;
    tick();
    rd_en = 0;
  endtask

  initial begin
    // 1 reset, including async reset mid-traffic
    tick();
    tick();
    rst_n = 1;
    tick();
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ferr", frame_err, 0);
    for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
    chk("pre_rst_level", level, 5);
    rst_n = 0;
    tick();
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_ovf", overflow, 0);
    rst_n = 1;
    sb.delete();
    mdl = 0;
    tick();

    // 2 order and first-word-fall-through latency
    wr(8'h11);
    chk("fwft_empty", empty, 0);
    chk("fwft_data", rd_data, 8'h11);
    wr(8'h22);
    wr(8'h33);
    chk("order_level", level, 3);
    for (int i = 0; i < 3; i++) pop("order_pop");
    chk("order_empty", empty, 1);
    rd_en = 1;
    tick();
    rd_en = 0;
    chk("rd_empty_level", level, 0);
    chk("rd_empty_flag", empty, 1);

    // 3 overflow with 17 writes
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill_full", full, 1);
    chk("fill_ovf", overflow, 0);
    wr(8'h10);
    chk("ovf_full", full, 1);
    chk("ovf_level", level, 16);
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 16; i++) pop("ovf_pop");
    chk("ovf_drain_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("ovf_clr", overflow, 0);

    // 4 interleaved write/read across pointer wrap
    maxlvl = 0;
    for (int i = 0; i < 40; i++) begin
      wr(8'(8'h80 + i));
      if (int'(level) > maxlvl) maxlvl = int'(level);
      pop("wrap_pop");
    end
    chk("wrap_maxlvl", maxlvl, 1);
    chk("wrap_empty", empty, 1);

    // 5 simultaneous read and write: full, then empty
    for (int i = 0; i < 16; i++) wr(8'(8'hA0 + i));
    chk("sim_full", full, 1);
    chk("sim_head", rd_data, sb.pop_front());
    sb.push_back(8'hAA);
    rx_data = 8'hAA;
    rx_done = 1;
    rd_en = 1;
    tick();
    rx_done = 0;
    rd_en = 0;
    chk("sim_full_level", level, 16);
    chk("sim_full_ovf", overflow, 0);
    chk("sim_full_flag", full, 1);
    for (int i = 0; i < 16; i++) pop("sim_pop");
    chk("sim_drain_empty", empty, 1);
    rx_data = 8'h55;
    rx_done = 1;
    rd_en = 1;
    tick();
    rx_done = 0;
    rd_en = 0;
    sb.push_back(8'h55);
    mdl = 1;
    chk("sim_empty_level", level, 1);
    chk("sim_empty_data", rd_data, 8'h55);
    pop("sim_empty_pop");

    // 6 framing error and almost_full
    rx_data = 8'h7E;
    rx_err = 1;
    rx_done = 1;
    tick();
    rx_done = 0;
    rx_err = 0;
`ifdef UART_RX_FIFO_STATUS_EN
    chk("ferr_set", frame_err, 1);
    chk("ferr_notstored", level, 0);
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("ferr_clr", frame_err, 0);
`else
    sb.push_back(8'h7E);
    mdl = 1;
    chk("ferr_off", frame_err, 0);
    chk("ferr_off_level", level, 1);
    pop("ferr_off_data");
`endif
    for (int i = 0; i < 11; i++) wr(8'(8'hC0 + i));
    chk("af_11", almost_full, 0);
    wr(8'hCB);
`ifdef UART_RX_FIFO_STATUS_EN
    chk("af_12", almost_full, 1);
`else
    chk("af_off", almost_full, 0);
`endif
    chk("af_level", level, 12);
    while (sb.size() > 0) pop("final_pop");
    chk("final_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
